prime_collector: RTL

- Downstream stage of the pipelined prime checker.
- Tags each candidate `number` driven to the checker and delays the tag by the checker's pipeline latency, so the tag lines up with the returning `prime` flag.
- Confirmed primes are buffered in a small FIFO and read out over a valid/ready interface.
- Also keeps a saturating prime count and a sticky overflow flag.

---
 rtl/prime_pkg.sv | 15 +
 rtl/prime_sync_fifo.sv | 64 ++++++
 rtl/prime_collector.sv | 105 ++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
// Shared constants and tag type for the prime checker / collector pair.
package prime_pkg;

  // Default candidate width; must match the checker's `number` width.
  localparam int unsigned NUM_W   = 8;
  // Default checker pipeline latency, in cycles.
  localparam int unsigned CHK_LAT = 3;

  // One tag-line stage at the default width.
  typedef struct packed {
    logic             valid;
    logic [NUM_W-1:0] num;
  } tag_t;

endpackage

// File: rtl/prime_sync_fifo.sv
// Synchronous FIFO with show-ahead read and an exact occupancy count.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
module prime_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against the current occupancy.
  always_comb begin
    empty   = (level == '0);
    full    = (level == FULL_LVL);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem[rd_ptr];
  end

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/prime_collector.sv
// Collects confirmed primes from the pipelined prime checker.
// Each candidate is tagged and delayed by the checker latency so the tag
// lines up with the returning `prime` flag; accepted primes are queued in
// a FIFO, counted (saturating) and overflow is flagged sticky.
// Optional: define PRIME_COLLECTOR_SMALL_GUARD_EN to reject `prime` for 0 and 1.
module prime_collector
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH   = NUM_W,
  parameter int unsigned LATENCY = CHK_LAT,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        number,
  input  logic                    prime,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_number,
  output logic [CNT_W-1:0]        prime_count,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic                    busy
);

  // Same layout as prime_pkg::tag_t, but sized by the WIDTH parameter.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] num;
  } stage_t;

  stage_t tags [LATENCY];
  stage_t aligned;
  logic   accept;
  logic   room;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;

  // Tag delay line: stage 0 captures the candidate every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{valid: in_valid, num: number};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  // Accept/push decision and busy indication.
  always_comb begin
    aligned = tags[LATENCY-1];
`ifdef PRIME_COLLECTOR_SMALL_GUARD_EN
    accept  = aligned.valid && prime && (|aligned.num[WIDTH-1:1]);
`else
    accept  = aligned.valid && prime;
`endif
    out_valid = !empty;
    pop       = out_valid && out_ready;
    room      = !full || pop;
    push      = accept && room;
    busy      = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      busy = busy | tags[i].valid;
    end
  end

  // Saturating prime counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (accept && (prime_count != '1)) begin
        prime_count <= prime_count + CNT_W'(1);
      end
      if (accept && !room) begin
        overflow <= 1'b1;
      end
    end
  end

  prime_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (aligned.num),
    .dout  (out_number),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

endmodule
